instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Produces the instruction stream that the instruction decoder consumes: holds the architectural PC and issues reads to instruction memory.
//  Buffers returned words and hands {instruction, instruction_pc} to decode over a valid/ready handshake.
//  Accepts the decoder's computed jump/branch target as a redirect, flushing buffered and in-flight wrong-path words.
// PARAMETERS
//  XLEN          32  data/address width
//  RESET_PC      0   PC loaded on reset; bits[1:0] must be 0
//  BUFFER_DEPTH  4   instruction buffer entries; also the credit limit (buffered + outstanding); power of 2, >=2
// PORTS
//  clk                in   1     clock, rising edge
//  rst                in   1     asynchronous, active-high reset
//  im_read_enable     out  1     fetch request valid
//  im_ready           in   1     imem accepts request this cycle
//  im_addr            out  XLEN  fetch address, always equal to pc_q
//  im_read_valid      in   1     imem response valid; responses return in request order
//  im_read_data       in   XLEN  imem response word
//  redirect_valid     in   1     decoder requests PC change (jump/taken branch)
//  redirect_pc        in   XLEN  new PC (decoder computed_PC)
//  instruction        out  XLEN  head instruction to decode
//  instruction_pc     out  XLEN  PC of head instruction
//  instruction_valid  out  1     head entry valid
//  instruction_ready  in   1     decoder consumes head
//  fetch_misaligned   out  1     1-cycle pulse: redirect target not 4-byte aligned
// BEHAVIOUR
//  Reset (async, immediate): pc_q=resp_pc_q=RESET_PC, buffer empty, outstanding=0, drop_cnt=0.
//   Outputs: im_read_enable=0, im_addr=RESET_PC, instruction_valid=0, instruction=0, instruction_pc=0, fetch_misaligned=0.
//  Credit: im_read_enable = ~redirect_valid & (occupancy + outstanding < BUFFER_DEPTH). Both counts are registered values.
//  Request accept (im_read_enable & im_ready): outstanding+1; pc_q <= pc_q+4, mod 2^XLEN (0xFFFFFFFC wraps to 0x0).
//  Response (im_read_valid):
//   - Ignored when outstanding==0 (protocol violation).
//   - Otherwise outstanding-1. If drop_cnt>0: drop_cnt-1 and the word is discarded.
//   - Else push {im_read_data, resp_pc_q} into the buffer, and resp_pc_q += 4.
//  Latency: request accepted cycle N, response cycle N+L; instruction_valid is asserted no earlier than N+L+1 (buffer is registered).
//  Throughput: 1 instr/cycle sustained when BUFFER_DEPTH >= L+2.
//  Decode handshake:
//   - instruction_valid = buffer non-empty & ~redirect_valid; instruction/instruction_pc show the head entry (0 when empty).
//   - Pop on instruction_valid & instruction_ready. Push and pop in the same cycle are both applied.
//   - Credit cannot overflow the buffer, so a push never finds it full.
//  Redirect (redirect_valid, redirect_pc[1:0]==0), effective in the same cycle:
//   - Buffer flushed; no pop, no request.
//   - pc_q <= redirect_pc; resp_pc_q <= redirect_pc.
//   - drop_cnt <= outstanding minus 1 if a response arrives this cycle; that response is discarded.
//   - New requests may issue from the next cycle while drop_cnt>0; in-order return makes counting exact.
//  Misaligned redirect (redirect_pc[1:0]!=0): ignored entirely (no flush, PC unchanged, instruction_valid still forced 0 that cycle).
//   fetch_misaligned is registered, high the following cycle only.
//  Invariant: occupancy + outstanding <= BUFFER_DEPTH; drop_cnt <= outstanding.
// STRUCTURE
//  Shared package riscv_pkg: XLEN, INSTR_BYTES=4, RESET_PC default, fetch_entry_t {instr, pc}.
//  Sub-module fetch_buffer: synchronous FIFO of fetch_entry_t with push, pop, same-cycle flush, and count.
//  Top level holds the PC, credit and drop counters.
// TESTING
//  1 Reset, imem L=1 always ready -> im_addr 0x0,0x4,0x8...; instruction_pc 0x0,0x4,0x8 in order, first valid 2 cycles after first accept.
//  2 instruction_ready=0 for 10 cycles -> occupancy+outstanding peaks at 4, im_read_enable=0; on release 4 words delivered in order, none lost.
//  3 Two outstanding (L=3), redirect_pc=0x100 -> both stale words dropped; next instruction_pc=0x100, then 0x104.
//  4 Redirect and response in the same cycle -> that response dropped, drop_cnt=outstanding-1, no wrong-path word ever valid.
//  5 redirect_pc=0x102 -> fetch_misaligned high next cycle only; sequential PCs continue unchanged.
//  6 RESET_PC=0xFFFFFFFC -> second im_addr 0x0; assert rst mid-stream -> all outputs at reset values same cycle, im_addr=RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer: circular FIFO of fetch entries with same-cycle flush.
module fetch_buffer
  import riscv_pkg::fetch_entry_t;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

  // Pointer and occupancy update; flush discards everything at once.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, stale-response dropping.
module instruction_fetch
  import riscv_pkg::fetch_entry_t;
  import riscv_pkg::INSTR_BYTES;
  import riscv_pkg::RESET_PC_DEFAULT;
#(
  parameter int              XLEN         = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int              BUFFER_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            im_read_enable,
  input  logic            im_ready,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_read_valid,
  input  logic [XLEN-1:0] im_read_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instruction_pc,
  output logic            instruction_valid,
  input  logic            instruction_ready,
  output logic            fetch_misaligned
);

  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            misaligned_q, misaligned_d;

  logic [CW-1:0]   occupancy;
  logic [CW:0]     credit_sum;
  logic            redirect_ok, req_fire, resp_fire, drop_hit;
  logic            push, pop, empty;
  fetch_entry_t    head, push_entry;

  assign redirect_ok = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign credit_sum  = {1'b0, occupancy} + {1'b0, outstanding_q};

  // Rst gating keeps the request line low during reset.
  assign im_read_enable = !rst && !redirect_valid &&
                          (credit_sum < (CW+1)'(BUFFER_DEPTH));
  assign im_addr   = pc_q;
  assign req_fire  = im_read_enable && im_ready;
  assign resp_fire = im_read_valid && (outstanding_q != '0);
  assign drop_hit  = resp_fire && (drop_cnt_q != '0);
  // A response landing on a redirect cycle is wrong-path by definition.
  assign push      = resp_fire && !drop_hit && !redirect_ok;

  assign instruction_valid = !empty && !redirect_valid;
  assign pop               = instruction_valid && instruction_ready;
  assign instruction       = empty ? '0 : head.instr;
  assign instruction_pc    = empty ? '0 : head.pc;
  assign fetch_misaligned  = misaligned_q;

  assign push_entry = '{instr: im_read_data, pc: resp_pc_q};

  fetch_buffer #(.DEPTH(BUFFER_DEPTH)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_ok),
    .head      (head),
    .empty     (empty),
    .count     (occupancy)
  );

  // Next-state for PC, response PC, credit and drop counters.
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    misaligned_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);

    case ({req_fire, resp_fire})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect_ok) begin
      pc_d       = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = outstanding_q - CW'(resp_fire);
    end else begin
      if (req_fire) pc_d = pc_q + STEP;
      if (push)     resp_pc_d = resp_pc_q + STEP;
      if (drop_hit) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Registered state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      misaligned_q  <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with an in-order imem model and
// a program-order reference of the expected decode stream.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        im_read_enable, im_ready, im_read_valid;
  logic [31:0] im_addr, im_read_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction, instruction_pc;
  logic        instruction_valid, instruction_ready, fetch_misaligned;

  logic        w_en, w_ready, w_valid, w_rvalid, w_iready, w_mis, w_redir;
  logic [31:0] w_addr, w_instr, w_ipc, w_rdata, w_rpc;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0), .BUFFER_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .im_read_enable(im_read_enable), .im_ready(im_ready), .im_addr(im_addr),
    .im_read_valid(im_read_valid), .im_read_data(im_read_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction(instruction), .instruction_pc(instruction_pc),
    .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
    .fetch_misaligned(fetch_misaligned)
  );

  instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .BUFFER_DEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst),
    .im_read_enable(w_en), .im_ready(w_ready), .im_addr(w_addr),
    .im_read_valid(w_rvalid), .im_read_data(w_rdata),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .instruction(w_instr), .instruction_pc(w_ipc),
    .instruction_valid(w_valid), .instruction_ready(w_iready),
    .fetch_misaligned(w_mis)
  );

  typedef struct { int due; logic [31:0] addr; } req_t;
  req_t        rq[$];
  logic [31:0] cons_pcs[$];

  int checks = 0, errors = 0;
  int cyc, last_due, lat, rdy_pct, dec_pct;
  int accepts, consumed, first_acc, first_val, mis_high, redir_idx;
  logic [31:0] exp_pc, fetch_pc;
  bit mis_prev;
  bit pend_redir, redir_on_resp;
  int redir_on_out;
  logic [31:0] pend_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    im_ready = 0; im_read_valid = 0; im_read_data = '0;
    redirect_valid = 0; redirect_pc = '0; instruction_ready = 0;
    rq.delete(); cons_pcs.delete();
    exp_pc = 32'h0; fetch_pc = 32'h0; mis_prev = 0;
    accepts = 0; consumed = 0; first_acc = -1; first_val = -1; mis_high = 0;
    redir_idx = -1; pend_redir = 0; redir_on_resp = 0; redir_on_out = -1;
    cyc = 0; last_due = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cycle();
    req_t r;
    int   out_now;
    @(negedge clk);
    cyc++;
    im_read_valid = 0; im_read_data = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      im_read_valid = 1; im_read_data = mem_word(r.addr);
    end
    out_now = rq.size() + (im_read_valid ? 1 : 0);
    im_ready          = ($urandom_range(0, 99) < rdy_pct);
    instruction_ready = ($urandom_range(0, 99) < dec_pct);
    redirect_valid = 0; redirect_pc = '0;
    if (pend_redir && (!redir_on_resp || im_read_valid) &&
        (redir_on_out < 0 || (out_now == redir_on_out && !im_read_valid))) begin
      redirect_valid = 1; redirect_pc = pend_target; pend_redir = 0;
      redir_idx = cons_pcs.size();
    end
    #1;
    checks++;
    if (fetch_misaligned !== mis_prev) begin
      errors++; $display("FAIL misaligned_pulse: got %b expected %b (cycle %0d)", fetch_misaligned, mis_prev, cyc);
    end
    if (fetch_misaligned) mis_high++;
    mis_prev = redirect_valid && (redirect_pc[1:0] != 2'b00);
    checks++;
    if (im_read_enable && out_now >= 4) begin
      errors++; $display("FAIL credit_limit: enable=1 with %0d outstanding", out_now);
    end
    if (redirect_valid) begin
      checks++;
      if (im_read_enable !== 1'b0 || instruction_valid !== 1'b0) begin
        errors++; $display("FAIL redirect_block: enable=%b valid=%b expected 0 0", im_read_enable, instruction_valid);
      end
    end
    if (im_read_enable && im_ready) begin
      checks++;
      if (im_addr !== fetch_pc) begin
        errors++; $display("FAIL im_addr: got %h expected %h", im_addr, fetch_pc);
      end
      r.due = cyc + lat;
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due; r.addr = im_addr;
      rq.push_back(r);
      fetch_pc += 4; accepts++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (instruction_valid && first_val < 0) first_val = cyc;
    if (instruction_valid && instruction_ready) begin
      checks++;
      if (instruction_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
        errors++; $display("FAIL decode_stream: got pc %h instr %h expected pc %h instr %h",
                           instruction_pc, instruction, exp_pc, mem_word(exp_pc));
      end
      cons_pcs.push_back(instruction_pc);
      exp_pc += 4; consumed++;
    end
    if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
      exp_pc = redirect_pc; fetch_pc = redirect_pc;
    end
  endtask

  task automatic wait_redirect(input string name);
    for (int i = 0; i < 60 && pend_redir; i++) cycle();
    checks++;
    if (pend_redir) begin
      errors++; $display("FAIL %s_timeout: redirect never issued", name);
      pend_redir = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (im_read_enable !== 1'b0 || im_addr !== 32'h0 || instruction_valid !== 1'b0 ||
        instruction !== 32'h0 || instruction_pc !== 32'h0 || fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: en=%b addr=%h v=%b i=%h pc=%h mis=%b expected 0 0 0 0 0 0",
                         im_read_enable, im_addr, instruction_valid, instruction, instruction_pc, fetch_misaligned);
    end
    checks++;
    if (w_addr !== 32'hFFFF_FFFC || w_en !== 1'b0) begin
      errors++; $display("FAIL reset_wrap_addr: got %h en=%b expected fffffffc en=0", w_addr, w_en);
    end
  endtask

  task automatic test_basic();
    do_reset();
    lat = 1; rdy_pct = 100; dec_pct = 100;
    repeat (20) cycle();
    checks++;
    if (first_val - first_acc !== 2) begin
      errors++; $display("FAIL first_latency: got %0d cycles expected 2", first_val - first_acc);
    end
    checks++;
    if (consumed !== 18) begin
      errors++; $display("FAIL throughput: got %0d instrs expected 18", consumed);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    lat = 1; rdy_pct = 100; dec_pct = 0;
    repeat (10) cycle();
    checks++;
    if (accepts !== 4 || im_read_enable !== 1'b0 || instruction_valid !== 1'b1) begin
      errors++; $display("FAIL stall_credit: accepts=%0d en=%b valid=%b expected 4 0 1",
                         accepts, im_read_enable, instruction_valid);
    end
    dec_pct = 100;
    repeat (4) cycle();
    checks++;
    if (consumed !== 4) begin
      errors++; $display("FAIL stall_release: got %0d delivered expected 4", consumed);
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat = 3; rdy_pct = 100; dec_pct = 100;
    pend_target = 32'h100; redir_on_out = 2; pend_redir = 1;
    wait_redirect("stale");
    repeat (20) cycle();
    checks++;
    if (redir_idx < 0 || cons_pcs.size() < redir_idx + 2 ||
        cons_pcs[redir_idx] !== 32'h100 || cons_pcs[redir_idx+1] !== 32'h104) begin
      errors++; $display("FAIL stale_drop: first post-redirect pcs wrong (idx %0d, n %0d) expected 100 104",
                         redir_idx, cons_pcs.size());
    end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    lat = 2; rdy_pct = 100; dec_pct = 100;
    repeat (6) cycle();
    pend_target = 32'h200; redir_on_resp = 1; pend_redir = 1;
    wait_redirect("resp");
    redir_on_resp = 0;
    repeat (20) cycle();
    checks++;
    if (redir_idx < 0 || cons_pcs.size() <= redir_idx || cons_pcs[redir_idx] !== 32'h200) begin
      errors++; $display("FAIL resp_drop: post-redirect stream does not start at 00000200 (n %0d)", cons_pcs.size());
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    lat = 1; rdy_pct = 100; dec_pct = 100;
    repeat (6) cycle();
    pend_target = 32'h102; pend_redir = 1;
    wait_redirect("mis");
    repeat (10) cycle();
    checks++;
    if (mis_high !== 1) begin
      errors++; $display("FAIL mis_pulse_count: got %0d expected 1", mis_high);
    end
    checks++;
    if (redir_idx < 1 || cons_pcs.size() <= redir_idx ||
        cons_pcs[redir_idx] !== cons_pcs[redir_idx-1] + 32'd4) begin
      errors++; $display("FAIL mis_sequential: stream not continuous across ignored redirect (idx %0d)", redir_idx);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin
        lat = $urandom_range(1, 4); rdy_pct = $urandom_range(50, 100); dec_pct = $urandom_range(40, 100);
      end
      r = $urandom_range(0, 99);
      if (!pend_redir && r < 8) begin
        pend_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        redir_on_resp = ($urandom_range(0, 1) == 1); redir_on_out = -1; pend_redir = 1;
      end else if (!pend_redir && r < 10) begin
        pend_target = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        redir_on_resp = 0; redir_on_out = -1; pend_redir = 1;
      end
      if (pend_redir && redir_on_resp && r > 90) redir_on_resp = 0;
      cycle();
    end
    checks++;
    if (consumed < 100) begin
      errors++; $display("FAIL random_progress: got %0d instrs expected >= 100", consumed);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    @(negedge clk);
    w_ready = 1'b1;
    #1;
    checks++;
    if (w_addr !== 32'hFFFF_FFFC || w_en !== 1'b1) begin
      errors++; $display("FAIL wrap_first: got %h en=%b expected fffffffc en=1", w_addr, w_en);
    end
    @(negedge clk);
    #1;
    checks++;
    if (w_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_second: got %h expected 00000000", w_addr);
    end
    w_ready = 1'b0;
    lat = 1; rdy_pct = 100; dec_pct = 50;
    repeat (10) cycle();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (im_read_enable !== 1'b0 || im_addr !== 32'h0 || instruction_valid !== 1'b0 ||
        instruction !== 32'h0 || instruction_pc !== 32'h0 || fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL midstream_reset: en=%b addr=%h v=%b i=%h pc=%h mis=%b expected 0 0 0 0 0 0",
                         im_read_enable, im_addr, instruction_valid, instruction, instruction_pc, fetch_misaligned);
    end
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    im_ready = 0; im_read_valid = 0; im_read_data = '0;
    redirect_valid = 0; redirect_pc = '0; instruction_ready = 0;
    w_ready = 0; w_rvalid = 0; w_rdata = '0; w_redir = 0; w_rpc = '0; w_iready = 0;
    lat = 1; rdy_pct = 100; dec_pct = 100;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_stale();
    test_redirect_resp();
    test_misaligned();
    test_random();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
